// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shape codes, circle geometry slot and FSM state type for shape_sequencer
package gpu_pkg;

    localparam int SHAPE_LINE     = 0;
    localparam int SHAPE_TRIANGLE = 1;
    localparam int SHAPE_POLY     = 2;
    localparam int SHAPE_CIRCLE   = 3;
    localparam int SHAPE_RECT     = 4;

    localparam int CIRCLE_SLOT    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IDENTIFY,
        ST_LOAD,
        ST_MAKE,
        ST_OUTPIX,
        ST_CLEAR,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/shape_sequencer_if.sv
// rtl/shape_sequencer_if.sv - command, rasteriser and FIFO handshake bundle for shape_sequencer
interface shape_sequencer_if #(
    parameter int SHAPEID_W = 4,
    parameter int VCNT_W    = 4,
    parameter int SEL_W     = 4,
    parameter int OCT_W     = 3
);
    logic                 new_shape;
    logic [SHAPEID_W-1:0] shapeid;
    logic [VCNT_W-1:0]    n_verts;
    logic                 data_ready;
    logic                 data_sent;
    logic                 line_done;
    logic                 arc_done;
    logic                 prim_sel;
    logic                 write;
    logic                 read;
    logic                 enable;
    logic [SEL_W-1:0]     output_sel;
    logic [OCT_W-1:0]     octant;
    logic                 shape_done;
    logic                 busy;
    logic                 err;

    modport master (
        output new_shape, shapeid, n_verts, data_ready, data_sent, line_done, arc_done,
        input  prim_sel, write, read, enable, output_sel, octant, shape_done, busy, err
    );

    modport slave (
        input  new_shape, shapeid, n_verts, data_ready, data_sent, line_done, arc_done,
        output prim_sel, write, read, enable, output_sel, octant, shape_done, busy, err
    );
endinterface

// File: rtl/shape_edge_counter.sv
// rtl/shape_edge_counter.sv - edge index k, edge count E, arc octant and circle flag
module shape_edge_counter #(
    parameter int SEL_W       = 4,
    parameter int NUM_OCTANTS = 8,
    parameter int OCT_W       = $clog2(NUM_OCTANTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [SEL_W-1:0] e_in,
    input  logic             circ_in,
    input  logic             k_inc,
    input  logic             k_clr,
    input  logic             oct_inc,
    output logic [SEL_W-1:0] k,
    output logic [OCT_W-1:0] octant,
    output logic             is_circle,
    output logic             last_edge,
    output logic             oct_zero
);
    logic [SEL_W-1:0] e;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            k         <= '0;
            e         <= '0;
            octant    <= '0;
            is_circle <= 1'b0;
        end else begin
            if (load) begin
                e         <= e_in;
                is_circle <= circ_in;
                k         <= '0;
            end else if (k_clr) begin
                k <= '0;
            end else if (k_inc) begin
                k <= k + 1'b1;
            end
            if (oct_inc)
                octant <= (octant == OCT_W'(NUM_OCTANTS - 1)) ? '0 : octant + 1'b1;
        end
    end

    assign last_edge = (k == e - 1'b1);
    assign oct_zero  = (octant == '0);

endmodule

// File: rtl/shape_sequencer.sv
// rtl/shape_sequencer.sv - expands a shape command into FIFO pushes, raster runs and pops
// Optional stall watchdog: SHAPE_SEQ_WATCHDOG_EN
module shape_sequencer
    import gpu_pkg::*;
#(
    parameter int MAX_EDGES   = 8,
    parameter int NUM_OCTANTS = 8,
    parameter int SEL_W       = 4,
    parameter int SHAPEID_W   = 4,
    parameter int VCNT_W      = 4
`ifdef SHAPE_SEQ_WATCHDOG_EN
    ,
    parameter int WD_CYCLES   = 1024
`endif
) (
    input  logic               clk,
    input  logic               reset,
    shape_sequencer_if.slave   bus
);
    localparam int OCT_W = $clog2(NUM_OCTANTS);

    state_t               state, state_next;
    logic [SHAPEID_W-1:0] sid;
    logic [VCNT_W-1:0]    nv;
    logic [SEL_W-1:0]     e_in, k;
    logic [OCT_W-1:0]     octant;
    logic                 circ_in, illegal, load_e, k_inc, k_clr, oct_inc;
    logic                 is_circle, last_edge, oct_zero, prim_done;
    logic                 wd_hit, wd_fired, wd_abort;

    assign sid = bus.shapeid;
    assign nv  = bus.n_verts;

    shape_edge_counter #(.SEL_W(SEL_W), .NUM_OCTANTS(NUM_OCTANTS), .OCT_W(OCT_W)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (state == ST_IDLE || state == ST_DONE || state == ST_ERR),
        .load      (load_e),
        .e_in      (e_in),
        .circ_in   (circ_in),
        .k_inc     (k_inc),
        .k_clr     (k_clr),
        .oct_inc   (oct_inc),
        .k         (k),
        .octant    (octant),
        .is_circle (is_circle),
        .last_edge (last_edge),
        .oct_zero  (oct_zero)
    );

    // A circle may only finish once the pixel interleave is back at octant 0.
    assign prim_done = is_circle ? (bus.arc_done && oct_zero) : bus.line_done;

`ifdef SHAPE_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            in_wait;

    assign in_wait = (state == ST_MAKE) || (state == ST_OUTPIX);
    assign wd_hit  = in_wait && (wd_cnt == WD_W'(WD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt   <= '0;
            wd_fired <= 1'b0;
            wd_abort <= 1'b0;
        end else begin
            wd_cnt   <= (in_wait && state_next == state) ? wd_cnt + 1'b1 : '0;
            wd_fired <= wd_hit;
            if (state == ST_IDLE)
                wd_abort <= 1'b0;
            else if (wd_hit)
                wd_abort <= 1'b1;
        end
    end
`else
    assign wd_hit   = 1'b0;
    assign wd_fired = 1'b0;
    assign wd_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_e     = 1'b0;
        k_inc      = 1'b0;
        k_clr      = 1'b0;
        oct_inc    = 1'b0;
        e_in       = '0;
        circ_in    = 1'b0;
        illegal    = 1'b0;

        case (int'(sid))
            SHAPE_LINE:     e_in = SEL_W'(1);
            SHAPE_TRIANGLE: e_in = SEL_W'(3);
            SHAPE_POLY: begin
                e_in    = SEL_W'(nv);
                illegal = (int'(nv) < 3) || (int'(nv) > MAX_EDGES);
            end
            SHAPE_CIRCLE: begin
                e_in    = SEL_W'(1);
                circ_in = 1'b1;
            end
            SHAPE_RECT:     e_in = SEL_W'(4);
            default:        illegal = 1'b1;
        endcase

        case (state)
            ST_IDLE:     if (bus.new_shape) state_next = ST_IDENTIFY;
            ST_IDENTIFY: begin
                load_e     = 1'b1;
                state_next = illegal ? ST_ERR : ST_LOAD;
            end
            ST_LOAD: begin
                if (last_edge) begin
                    k_clr      = 1'b1;
                    state_next = ST_MAKE;
                end else begin
                    k_inc = 1'b1;
                end
            end
            ST_MAKE: begin
                if (wd_hit)
                    state_next = ST_CLEAR;
                else if (bus.data_ready)
                    state_next = ST_OUTPIX;
                else if (prim_done)
                    state_next = ST_CLEAR;
            end
            ST_OUTPIX: begin
                if (wd_hit) begin
                    state_next = ST_CLEAR;
                end else if (bus.data_sent) begin
                    state_next = ST_MAKE;
                    oct_inc    = is_circle;
                end
            end
            ST_CLEAR: begin
                if (last_edge) begin
                    state_next = ST_DONE;
                end else begin
                    k_inc      = 1'b1;
                    state_next = wd_abort ? ST_CLEAR : ST_MAKE;
                end
            end
            ST_DONE:     state_next = ST_IDLE;
            ST_ERR:      state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    assign bus.write      = (state == ST_LOAD);
    assign bus.read       = (state == ST_CLEAR);
    assign bus.enable     = (state == ST_MAKE);
    assign bus.shape_done = (state == ST_DONE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.err        = (state == ST_ERR) || wd_fired;
    assign bus.prim_sel   = is_circle;
    assign bus.octant     = octant;
    assign bus.output_sel = (state != ST_LOAD) ? '0 :
                            is_circle ? SEL_W'(CIRCLE_SLOT) : k;

endmodule

// File: tb/tb_shape_sequencer.sv
// tb/tb_shape_sequencer.sv - scoreboard bench for shape_sequencer
module tb_shape_sequencer;
    import gpu_pkg::*;

    localparam int SEL_W     = 4;
    localparam int SHAPEID_W = 4;
    localparam int VCNT_W    = 4;
    localparam int OCT_W     = 3;

    localparam int EV_W = 0;
    localparam int EV_E = 1;
    localparam int EV_R = 2;
    localparam int EV_D = 3;
    localparam int EV_P = 4;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   t0    = 0;
    ev_t  q[$];

    shape_sequencer_if #(.SHAPEID_W(SHAPEID_W), .VCNT_W(VCNT_W), .SEL_W(SEL_W), .OCT_W(OCT_W)) bus ();

    shape_sequencer #(
        .MAX_EDGES(8), .NUM_OCTANTS(8), .SEL_W(SEL_W), .SHAPEID_W(SHAPEID_W), .VCNT_W(VCNT_W)
`ifdef SHAPE_SEQ_WATCHDOG_EN
        , .WD_CYCLES(16)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_ev(int kind, int val);
        ev_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event got kind=%0d val=%0d cyc=%0d, required none", kind, val, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.val != val || (e.cyc >= 0 && e.cyc != cyc)) begin
                fails++;
                $display("FAIL event got kind=%0d val=%0d cyc=%0d, required kind=%0d val=%0d cyc=%0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.write)      check_ev(EV_W, int'(bus.prim_sel) * 16 + int'(bus.output_sel));
            if (bus.err)        check_ev(EV_E, 0);
            if (bus.read)       check_ev(EV_R, 0);
            if (bus.shape_done) check_ev(EV_D, 0);
            if (bus.data_sent && bus.busy && !bus.enable) check_ev(EV_P, int'(bus.octant));
        end
    end

    task automatic chk(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int kind, int val, int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        q.push_back(e);
    endtask

    function automatic int all_outputs();
        return int'({bus.prim_sel, bus.write, bus.read, bus.enable, bus.output_sel,
                     bus.octant, bus.shape_done, bus.busy, bus.err});
    endfunction

    task automatic wait_enable();
        int n = 0;
        while (!bus.enable && n < 60) begin
            tick();
            n++;
        end
        if (!bus.enable) begin
            tests++;
            fails++;
            $display("FAIL enable_timeout got 0 required 1 at cyc %0d", cyc);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        chk("return_to_idle", int'(bus.busy), 0);
    endtask

    task automatic start(int code, int nv);
        bus.shapeid   = SHAPEID_W'(code);
        bus.n_verts   = VCNT_W'(nv);
        bus.new_shape = 1'b1;
        t0 = cyc;
        tick();
        bus.new_shape = 1'b0;
    endtask

    task automatic push_writes(int e, bit circ);
        for (int i = 0; i < e; i++)
            push(EV_W, circ ? 16 + 4 : i, t0 + 2 + i);
    endtask

    task automatic pixel(int dly, int oct);
        wait_enable();
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        repeat (dly) tick();
        push(EV_P, oct, -1);
        bus.data_sent = 1'b1;
        tick();
        bus.data_sent = 1'b0;
    endtask

    task automatic end_prim(bit arc);
        wait_enable();
        push(EV_R, 0, -1);
        if (arc) bus.arc_done = 1'b1;
        else     bus.line_done = 1'b1;
        tick();
        bus.arc_done  = 1'b0;
        bus.line_done = 1'b0;
    endtask

    task automatic finish_shape();
        push(EV_D, 0, -1);
        wait_idle();
    endtask

    initial begin
        bus.new_shape  = 1'b0;
        bus.shapeid    = '0;
        bus.n_verts    = '0;
        bus.data_ready = 1'b0;
        bus.data_sent  = 1'b0;
        bus.line_done  = 1'b0;
        bus.arc_done   = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", all_outputs(), 0);
        reset = 1'b0;
        tick();
        chk("idle_outputs", all_outputs(), 0);

        // zero-pixel line: write at t+2, read at t+4, shape_done at t+5
        start(SHAPE_LINE, 0);
        push_writes(1, 1'b0);
        wait_enable();
        push(EV_R, 0, t0 + 4);
        bus.line_done = 1'b1;
        tick();
        bus.line_done = 1'b0;
        push(EV_D, 0, t0 + 5);
        wait_idle();

        // line with 3 slow pixels; a stray new_shape while busy must be ignored
        start(SHAPE_LINE, 0);
        push_writes(1, 1'b0);
        wait_enable();
        bus.new_shape = 1'b1;
        tick();
        bus.new_shape = 1'b0;
        chk("new_shape_ignored_busy", int'(bus.enable), 1);
        for (int i = 0; i < 3; i++) pixel(2, 0);
        end_prim(1'b0);
        finish_shape();

        start(SHAPE_TRIANGLE, 0);
        push_writes(3, 1'b0);
        for (int e = 0; e < 3; e++) begin
            pixel(0, 0);
            pixel(0, 0);
            end_prim(1'b0);
        end
        finish_shape();

        start(SHAPE_POLY, 5);
        push_writes(5, 1'b0);
        for (int e = 0; e < 5; e++) begin
            pixel(1, 0);
            end_prim(1'b0);
        end
        finish_shape();

        start(SHAPE_RECT, 0);
        push_writes(4, 1'b0);
        for (int e = 0; e < 4; e++) end_prim(1'b0);
        finish_shape();

        // illegal commands: err at t+2, nothing pushed
        start(SHAPE_POLY, 2);
        push(EV_E, 0, t0 + 2);
        wait_idle();
        start(SHAPE_POLY, 9);
        push(EV_E, 0, t0 + 2);
        wait_idle();
        start(7, 0);
        push(EV_E, 0, t0 + 2);
        wait_idle();

        // circle: 16 pixels over 8 octants, early arc_done at octant 3 ignored
        start(SHAPE_CIRCLE, 0);
        push_writes(1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            pixel(0, i % 8);
            if (i == 2) begin
                wait_enable();
                chk("circle_prim_sel", int'(bus.prim_sel), 1);
                bus.arc_done = 1'b1;
                tick();
                bus.arc_done = 1'b0;
                chk("arc_done_ignored_octant3", int'(bus.enable), 1);
            end
        end
        end_prim(1'b1);
        finish_shape();

        // data_ready and line_done together: pixel first, then CLEAR
        start(SHAPE_LINE, 0);
        push_writes(1, 1'b0);
        wait_enable();
        bus.data_ready = 1'b1;
        bus.line_done  = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        chk("pixel_before_done", int'({bus.enable, bus.read}), 0);
        push(EV_P, 0, -1);
        bus.data_sent = 1'b1;
        tick();
        bus.data_sent = 1'b0;
        push(EV_R, 0, -1);
        tick();
        bus.line_done = 1'b0;
        finish_shape();

        // reset mid-OUTPIX on a circle with a non-zero octant
        start(SHAPE_CIRCLE, 0);
        push_writes(1, 1'b1);
        for (int i = 0; i < 3; i++) pixel(0, i);
        wait_enable();
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        reset = 1'b1;
        tick();
        chk("reset_mid_outpix", all_outputs(), 0);
        reset = 1'b0;
        tick();
        chk("after_reset_idle", all_outputs(), 0);

`ifdef SHAPE_SEQ_WATCHDOG_EN
        // stalled pixel on a triangle: err after 16 cycles, remaining pops, done
        start(SHAPE_TRIANGLE, 0);
        push_writes(3, 1'b0);
        wait_enable();
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        push(EV_E, 0, cyc + 16);
        push(EV_R, 0, cyc + 16);
        push(EV_R, 0, cyc + 17);
        push(EV_R, 0, cyc + 18);
        push(EV_D, 0, cyc + 19);
        wait_idle();
`endif

        repeat (3) tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shape_sequencer.md
Name: shape_sequencer

Overview:
- Parametrised successor to the per-shape core control FSM in the 2D GPU pipeline.
- Sits between the shape command decoder and the line/arc rasteriser plus its primitive FIFO.
- Expands one shape command into N primitives. It pushes them into the FIFO, runs the rasteriser per primitive, hands each pixel to the display writer, then pops the FIFO and flags shape completion.
- Uses edge and octant counters instead of replicated per-edge and per-arc states. Supports line, triangle, rectangle, N-gon and circle.

Parameters:
- MAX_EDGES, 8, maximum primitives per polygon shape (≥4).
- NUM_OCTANTS, 8, arcs a circle is split into; round-robin pixel interleave.
- SEL_W, 4, width of output_sel; must satisfy 2^SEL_W ≥ MAX_EDGES+1.
- SHAPEID_W, 4, width of shapeid.
- VCNT_W, 4, width of n_verts.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- new_shape  in  1  one-cycle pulse; shape command valid.
- shapeid  in  SHAPEID_W  shape code; sampled in IDENTIFY.
- n_verts  in  VCNT_W  vertex count for N-gon; sampled in IDENTIFY.
- data_ready  in  1  rasteriser has a pixel.
- data_sent  in  1  display writer accepted the pixel.
- line_done  in  1  line rasteriser finished the current primitive.
- arc_done  in  1  arc rasteriser finished the circle.
- prim_sel  out  1  0 = line engine, 1 = arc engine.
- write  out  1  FIFO push strobe.
- read  out  1  FIFO pop strobe.
- enable  out  1  rasteriser step enable.
- output_sel  out  SEL_W  primitive/vertex-pair index for the geometry mux.
- octant  out  $clog2(NUM_OCTANTS)  current arc octant.
- shape_done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state ≠ IDLE.
- err  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Moore outputs, decoded from registered state and counters only.
- On reset, and in IDLE, every output is 0.
- Reset asserted mid-shape: next edge goes to IDLE, counters clear, no shape_done.
- Shape codes:
  - LINE = 0: 1 edge.
  - TRIANGLE = 1: 3 edges.
  - POLY = 2: n_verts edges.
  - CIRCLE = 3: 1 arc primitive.
  - RECT = 4: 4 edges.
- Illegal command: any other code, or POLY with n_verts < 3 or > MAX_EDGES. Result is err = 1 for one cycle, then IDLE.
- States:
  - IDLE: goes to IDENTIFY on new_shape. new_shape is ignored while busy.
  - IDENTIFY: latches edge count E (circle E = 1), clears k. Goes to LOAD.
  - LOAD: write = 1, output_sel = k, one push per cycle. Goes to MAKE after k = E-1, then k clears. Circle: output_sel = 4 (circle geometry slot), prim_sel = 1.
  - MAKE: enable = 1.
    - If data_ready, go to OUTPIX.
    - Else if done, go to CLEAR. Done is line_done, or arc_done for a circle.
    - Else hold.
    - data_ready has priority over done, so no pixel is dropped.
    - Circle: arc_done is honoured only when octant = 0.
  - OUTPIX: enable = 0. Holds until data_sent = 1, then returns to MAKE. Circle: octant increments mod NUM_OCTANTS on leaving.
  - CLEAR: read = 1 for exactly one cycle.
    - k < E-1: increment k, go to MAKE.
    - Otherwise: go to DONE.
  - DONE: shape_done = 1. Goes to IDLE.
- prim_sel = 1 throughout a circle shape, 0 otherwise.
- output_sel = 0 outside LOAD.
- Latency: new_shape at cycle t gives the first write at t+2. A line with zero pixels (line_done first MAKE cycle) gives shape_done at t+5.
- Total writes per shape equal total reads per shape. The FIFO is empty again after DONE.

Optional Feature:
- Macro SHAPE_SEQ_WATCHDOG_EN.
- When defined:
  - Adds parameter WD_CYCLES (default 1024) and a cycle counter that runs in MAKE and OUTPIX.
  - The counter clears on every state change.
  - If it reaches WD_CYCLES: err pulses, the FSM goes to CLEAR and pops the remaining entries. It pops the current entry, then one entry per cycle until E reads are done, then goes to DONE.
- When undefined: no counter; MAKE and OUTPIX wait indefinitely; err is driven only by illegal commands.

Decomposition:
- Package gpu_pkg holds:
  - shape code constants.
  - The circle geometry slot constant (4).
  - The state enum typedef.
- One natural sub-module: shape_edge_counter, holding k, E, the octant counter, and the last-edge/octant-zero flags. The FSM stays in the top module.

Test Plan:
- LINE: 3 pixels, data_sent delayed 2 cycles each → 1 write, 3 OUTPIX waits, 1 read, shape_done exactly once.
- TRIANGLE: 2 pixels per edge → writes with output_sel 0, 1, 2 on consecutive cycles; 6 pixel handshakes; 3 reads; shape_done.
- POLY n_verts = 5 → 5 writes, 5 reads; n_verts = 2 and n_verts = 9 → err pulse, no write, back to IDLE.
- CIRCLE: 16 pixels → octant sequence 0..7, 0..7; arc_done asserted at octant 3 is ignored and honoured at octant 0; 1 read; shape_done.
- data_ready and line_done high in the same MAKE cycle → OUTPIX taken first, CLEAR on the following MAKE; reset asserted mid-OUTPIX → all outputs 0 next cycle.
- With SHAPE_SEQ_WATCHDOG_EN and WD_CYCLES = 16, data_sent stuck low on a triangle → err after 16 cycles, 3 reads total, shape_done.
